// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program memory.
package prog_mem_pkg;

  // LOAD accepts words from the loader, RUN serves instruction fetches
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ARM "MOV R0,R0", the word handed back for any fetch that cannot be served
  localparam logic [31:0] ARM_NOP = 32'hE1A00000;

endpackage

// File: rtl/prog_mem_loader.sv
// Load sequencer: tracks the LOAD/RUN mode, the write pointer and the
// number of valid words stored so far.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          run,
  output logic          wr_en,
  output logic [AW-1:0] waddr,
  output logic [CW-1:0] count
);

  state_t        state, state_next;
  logic [CW-1:0] wptr, wptr_next;
  logic [CW-1:0] count_q, count_next;

  // State, pointer and count registers; reset discards any partial load
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOAD;
      wptr    <= '0;
      count_q <= '0;
    end else begin
      state   <= state_next;
      wptr    <= wptr_next;
      count_q <= count_next;
    end
  end

  // Accept one word per handshake and leave LOAD on the last or the DEPTH-th word
  always_comb begin
    state_next = state;
    wptr_next  = wptr;
    count_next = count_q;
    ld_ready   = 1'b0;
    run        = 1'b0;
    wr_en      = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          // a handshake coinciding with reset must not reach the array
          wr_en      = !reset;
          wptr_next  = wptr + CW'(1);
          count_next = wptr + CW'(1);
          if (ld_last || (wptr == CW'(DEPTH - 1))) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        run = 1'b1;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  assign waddr = wptr[AW-1:0];
  assign count = count_q;

endmodule

// File: rtl/prog_mem.sv
// Program memory: loaded word by word, then serves fetches by byte address.
// Optional macro PROG_MEM_REG_RD_EN registers rd/addr_err (one cycle latency);
// without it the fetch path is purely combinational.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(ARM_NOP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [31:0]       a,
  output logic [DATA_W-1:0] rd,
  output logic              run,
  output logic              addr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic              wr_en;
  logic [AW-1:0]     waddr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [29:0]       idx;
  logic              idx_ok;
  logic [DATA_W-1:0] rd_comb;
  logic              err_comb;

  prog_mem_loader #(
    .DEPTH (DEPTH)
  ) u_loader (
    .clk      (clk),
    .reset    (reset),
    .ld_valid (ld_valid),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .run      (run),
    .wr_en    (wr_en),
    .waddr    (waddr),
    .count    (count)
  );

  // Instruction storage; never cleared, stale words are hidden by the count check
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= ld_data;
    end
  end

  assign idx    = a[31:2];
  assign idx_ok = (idx < 30'(DEPTH)) && (idx < 30'(count));

  // Fetch decode: NOP while loading, NOP plus error when out of the loaded range
  always_comb begin
    rd_comb  = NOP_WORD;
    err_comb = 1'b0;
    if (run) begin
      if (idx_ok) begin
        rd_comb  = mem[idx[AW-1:0]];
        err_comb = (a[1:0] != 2'b00);
      end else begin
        err_comb = 1'b1;
      end
    end
  end

`ifdef PROG_MEM_REG_RD_EN
  // Registered fetch result, valid the cycle after the address is presented
  always_ff @(posedge clk) begin
    if (reset) begin
      rd       <= NOP_WORD;
      addr_err <= 1'b0;
    end else begin
      rd       <= rd_comb;
      addr_err <= err_comb;
    end
  end
`else
  assign rd       = rd_comb;
  assign addr_err = err_comb;
`endif

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: queue-based reference model checked every cycle, plus
// literal expectations for the documented load/fetch scenarios.
module tb_prog_mem;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic [31:0] a;
  logic [31:0] rd;
  logic        run;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  prog_mem #(
    .DATA_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .a        (a),
    .rd       (rd),
    .run      (run),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  // reference model: the loaded program as a queue plus a running flag
  logic [31:0] model_words[$];
  bit          model_run   = 1'b0;
  bit          model_valid = 1'b0;
  logic [31:0] exp_rd_q;
  logic        exp_err_q;
  logic [31:0] cmp_rd;
  logic        cmp_err;

  function automatic void expect_fetch(input logic [31:0] addr,
                                       output logic [31:0] e_rd,
                                       output logic e_err);
    int unsigned word_idx;
    word_idx = addr >> 2;
    if (!model_run) begin
      e_rd  = NOP;
      e_err = 1'b0;
    end else if (word_idx >= model_words.size()) begin
      e_rd  = NOP;
      e_err = 1'b1;
    end else begin
      e_rd  = model_words[word_idx];
      e_err = (addr % 4) != 0;
    end
  endfunction

  // model update on each rising edge, from the inputs held across that edge
  always @(posedge clk) begin
`ifdef PROG_MEM_REG_RD_EN
    if (reset) begin
      exp_rd_q  = NOP;
      exp_err_q = 1'b0;
    end else begin
      expect_fetch(a, exp_rd_q, exp_err_q);
    end
`endif
    if (reset) begin
      model_words.delete();
      model_run   = 1'b0;
      model_valid = 1'b1;
    end else if (!model_run && ld_valid) begin
      model_words.push_back(ld_data);
      if (ld_last || model_words.size() == DEPTH) model_run = 1'b1;
    end
  end

  task automatic cmp_word(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (model_valid) begin
`ifdef PROG_MEM_REG_RD_EN
      cmp_rd  = exp_rd_q;
      cmp_err = exp_err_q;
`else
      expect_fetch(a, cmp_rd, cmp_err);
`endif
      cmp_bit("model_run", run, model_run);
      cmp_bit("model_ld_ready", ld_ready, !model_run);
      cmp_word("model_rd", rd, cmp_rd);
      cmp_bit("model_addr_err", addr_err, cmp_err);
    end
  end

  // drive one clock cycle of inputs, returning just after the rising edge
  task automatic apply_stimulus(input logic rst, input logic valid, input logic [31:0] data,
                                input logic last, input logic [31:0] addr);
    reset    = rst;
    ld_valid = valid;
    ld_data  = data;
    ld_last  = last;
    a        = addr;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // present an address and compare the fetch result against literal values
  task automatic check_output(input string name, input logic [31:0] addr,
                              input logic [31:0] exp_rd, input logic exp_err);
    a = addr;
`ifdef PROG_MEM_REG_RD_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    cmp_word({name, "_rd"}, rd, exp_rd);
    cmp_bit({name, "_err"}, addr_err, exp_err);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = 32'($urandom_range(0, 70)) << 2;
      1:       r = (32'($urandom_range(0, 70)) << 2) | 32'($urandom_range(1, 3));
      2:       r = $urandom();
      default: r = 32'($urandom_range(0, 300));
    endcase
    return r;
  endfunction

  logic [31:0] prog [7] = '{32'hE0400000, 32'hE2801004, 32'hE2802004, 32'hE1510002,
                            32'h0A000000, 32'hE5802064, 32'hE1710002};
  logic [31:0] stream [DEPTH];

  initial begin
    reset    = 1'b1;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    a        = '0;
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // reset state and fetch during LOAD
    cmp_bit("reset_run", run, 1'b0);
    cmp_bit("reset_ld_ready", ld_ready, 1'b1);
    cmp_word("reset_rd", rd, NOP);
    check_output("load_fetch0", 32'h0, NOP, 1'b0);

    // seven-word program, last flagged on the seventh word
    for (int i = 0; i < 7; i++) begin
      if (i == 6) cmp_bit("run_before_last", run, 1'b0);
      apply_stimulus(1'b0, 1'b1, prog[i], i == 6, 32'h0);
    end
    cmp_bit("run_after_last", run, 1'b1);
    cmp_bit("ld_ready_in_run", ld_ready, 1'b0);
    check_output("fetch_0c", 32'h0C, 32'hE1510002, 1'b0);
    check_output("fetch_1c", 32'h1C, NOP, 1'b1);
    check_output("fetch_06", 32'h06, 32'hE2801004, 1'b1);
    check_output("fetch_100", 32'h100, NOP, 1'b1);
    check_output("fetch_04", 32'h04, 32'hE2801004, 1'b0);
    check_output("fetch_18", 32'h18, 32'hE1710002, 1'b0);

    // full-depth stream without last, then ignored writes in RUN
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      stream[i] = $urandom();
      if (i == DEPTH - 1) cmp_bit("run_before_64th", run, 1'b0);
      apply_stimulus(1'b0, 1'b1, stream[i], 1'b0, rand_addr());
    end
    cmp_bit("run_after_64th", run, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0);
    check_output("full_word0", 32'h0, stream[0], 1'b0);
    check_output("full_word63", 32'hFC, stream[DEPTH-1], 1'b0);
    check_output("full_beyond", 32'h100, NOP, 1'b1);

    // reset mid-load (coinciding with a handshake) then a two-word reload
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 32'hA0000000 + i, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b1, 32'h12345678, 1'b0, 32'h0);
    cmp_bit("midreset_run", run, 1'b0);
    apply_stimulus(1'b0, 1'b1, 32'hB0000000, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 32'hB0000001, 1'b1, 32'h0);
    cmp_bit("reload_run", run, 1'b1);
    check_output("reload_08", 32'h08, NOP, 1'b1);
    check_output("reload_04", 32'h04, 32'hB0000001, 1'b0);
    check_output("reload_00", 32'h00, 32'hB0000000, 1'b0);

    // randomized loads with gaps, random last, occasional resets and random fetches
    for (int iter = 0; iter < 20; iter++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, rand_addr());
      for (int cyc = 0; cyc < 150; cyc++) begin
        apply_stimulus($urandom_range(0, 79) == 0, $urandom_range(0, 9) < 7, $urandom(),
                       $urandom_range(0, 19) == 0, rand_addr());
      end
      for (int cyc = 0; cyc < 30; cyc++) begin
        apply_stimulus(1'b0, $urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 1) == 1,
                       rand_addr());
      end
    end

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
